bram_read_arbiter: RTL and testbench
====================================

// Module: bram_read_arbiter
// PURPOSE
// - Shares the single read port (port A) of the audio sample BRAM between two requesters:
//   r0 = WM8731 DAC playback fetch, r1 = debug/readback path.
// - One grant per cycle; tracks every in-flight read through the fixed BRAM read latency.
// - Steers the returned douta to the requester that issued it, with a per-requester rvalid.
// - Sits between the requesters and the BRAM; owns bram_addra/bram_ena outright.
// PARAMETERS
// - ADDR_W       32  BRAM address width.
// - DATA_W       32  BRAM data width.
// - READ_LATENCY 1   clocks from the addra-sampling edge to valid douta; legal range 1..4.
// - POLICY       0   0 = round-robin, 1 = fixed priority (r0 wins).
// - STARVE_LIMIT 8   POLICY=1 only: after this many consecutive r1 losses, r1 wins the next tie.
// PORTS
// - clk        in   1       system clock; all state updates on posedge.
// - rst        in   1       asynchronous, active-high reset.
// - r0_req     in   1       r0 read request; held with r0_addr stable until r0_gnt.
// - r0_addr    in   ADDR_W  r0 read address.
// - r0_gnt     out  1       r0 request accepted this cycle (combinational).
// - r0_rvalid  out  1       r0_rdata valid this cycle.
// - r0_rdata   out  DATA_W  read data for r0.
// - r1_req / r1_addr / r1_gnt / r1_rvalid / r1_rdata: same as r0 for requester r1.
// - bram_ena   out  1       BRAM port A enable; high in every grant cycle.
// - bram_addra out  ADDR_W  BRAM port A address.
// - bram_douta in   DATA_W  BRAM port A read data.
// BEHAVIOUR
// - Reset values: r*_gnt=0, r*_rvalid=0, bram_ena=0, bram_addra=0. Tag pipe cleared,
//   RR pointer = "r1 last", starvation counter = 0. While rst is high, gnts are forced 0.
// - Grant (combinational): at most one of r0_gnt/r1_gnt per cycle. A gnt only goes high
//   with its req. bram_ena = r0_gnt|r1_gnt.
// - bram_addra = granted requester's addr; 0 when no grant.
// - Round-robin: on a tie, grant the requester not granted most recently. The pointer
//   updates only on a grant edge. A lone request is granted the same cycle.
// - Fixed priority: r0 wins ties unless starve_cnt == STARVE_LIMIT. starve_cnt increments
//   (saturating) on each tie r1 loses, and clears when r1 is granted.
// - Tag pipeline: READ_LATENCY stages of {valid,id}, loaded at every edge with
//   {bram_ena, granted id}. Stage READ_LATENCY drives rX_rvalid = valid & (id==X).
// - Latency: a grant in cycle N gives rvalid in cycle N+READ_LATENCY. Back-to-back grants
//   give back-to-back rvalids in grant order. No reordering, no drops.
// - r0_rdata = r1_rdata = bram_douta (combinational). Value is meaningful only with rvalid.
// - Requester protocol: req with no gnt -> hold req/addr. Deasserting req before gnt
//   withdraws the request; this is legal.
// - Reset mid-operation: all in-flight tags are discarded. No rvalid until new grants.
// - The arbiter never stalls. Full throughput is one read per clock.
// STRUCTURE
// - Shared package audio_mem_pkg: ADDR_W/DATA_W defaults, requester id
//   constants (REQ_DAC=0, REQ_DBG=1), MAX_READ_LATENCY=4.
// - Sub-module rd_tag_pipe: parameterised {valid,id} shift register with async clear.
// - Grant logic, the RR pointer and the starvation counter stay in this module.
// TESTING (bench BRAM model: douta <= addra^4 registered, READ_LATENCY=1)
// - Single r0 read, addr=3 -> r0_gnt same cycle, bram_addra=3; next cycle r0_rvalid=1, r0_rdata=81, r1_rvalid=0.
// - POLICY=0, r0 and r1 request continuously (addr 2 and 5) -> gnts alternate r0,r1,r0,...;
//   rdata alternates 16 and 625, each paired with the matching rvalid.
// - POLICY=1, STARVE_LIMIT=2, both requesting continuously -> grant order r0,r0,r1,r0,r0,r1,...
// - Back-to-back r1 reads, addr 1,2,3 on consecutive cycles -> r1_rvalid high 3 consecutive cycles, data 1,16,81.
// - Assert rst in the cycle after the r0 grant of addr=4 -> r0_rvalid never asserts;
//   all outputs are 0 during reset; the first post-reset tie goes to r0 (RR).
// - READ_LATENCY=3 build, r0 addr=2 -> r0_rvalid exactly 3 cycles after the grant, rdata=16.

Source files
------------

// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio sample BRAM read path: bus widths, requester ids
// and the {valid,id} tag that follows each read through the BRAM latency.
package audio_mem_pkg;

  localparam int ADDR_W_DEFAULT   = 32;
  localparam int DATA_W_DEFAULT   = 32;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    REQ_DAC = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/bram_read_arbiter_if.sv
// One requester's view of the shared BRAM read port: request/address out,
// same-cycle grant and latency-delayed read data back.
interface bram_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid,id} tags matching the BRAM read latency; an async reset
// discards every read still in flight.
module rd_tag_pipe
  import audio_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/bram_read_arbiter.sv
// Arbitrates BRAM port A reads between the DAC fetch (r0) and the debug path (r1),
// and steers returned data back to the issuer once the read latency has elapsed.
module bram_read_arbiter
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int READ_LATENCY = 1,
  parameter int POLICY       = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_read_arbiter_if.slave   r0,
  bram_read_arbiter_if.slave   r1,
  output logic                 bram_ena,
  output logic [ADDR_W-1:0]    bram_addra,
  input  logic [DATA_W-1:0]    bram_douta
);

  localparam int SC_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic            gnt0;
  logic            gnt1;
  logic            tie;
  logic            dbg_wins;
  req_id_t         grant_id;
  req_id_t         rr_last_reg;
  req_id_t         rr_last_next;
  logic [SC_W-1:0] starve_reg;
  logic [SC_W-1:0] starve_next;
  rd_tag_t         tag_in;
  rd_tag_t         tag_out;

  // Tie-break: round-robin favours whoever was not granted last; fixed priority
  // favours r0 until r1 has lost STARVE_LIMIT ties in a row.
  always_comb begin
    tie      = r0.req & r1.req;
    dbg_wins = 1'b0;
    if (POLICY == 0) begin
      dbg_wins = (rr_last_reg == REQ_DAC);
    end else begin
      dbg_wins = (starve_reg == STARVE_MAX);
    end
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (tie) begin
        gnt0 = !dbg_wins;
        gnt1 = dbg_wins;
      end else begin
        gnt0 = r0.req;
        gnt1 = r1.req;
      end
    end
  end

  assign grant_id   = gnt1 ? REQ_DBG : REQ_DAC;
  assign bram_ena   = gnt0 | gnt1;
  assign bram_addra = gnt0 ? r0.addr : (gnt1 ? r1.addr : '0);

  always_comb begin
    rr_last_next = rr_last_reg;
    starve_next  = starve_reg;
    if (bram_ena) begin
      rr_last_next = grant_id;
    end
    if (POLICY != 0) begin
      if (gnt1) begin
        starve_next = '0;
      end else if (tie && gnt0 && (starve_reg != STARVE_MAX)) begin
        starve_next = starve_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_reg <= REQ_DBG;
      starve_reg  <= '0;
    end else begin
      rr_last_reg <= rr_last_next;
      starve_reg  <= starve_next;
    end
  end

  assign tag_in = '{valid: bram_ena, id: grant_id};

  rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign r0.gnt    = gnt0;
  assign r1.gnt    = gnt1;
  assign r0.rvalid = tag_out.valid && (tag_out.id == REQ_DAC);
  assign r1.rvalid = tag_out.valid && (tag_out.id == REQ_DBG);
  assign r0.rdata  = bram_douta;
  assign r1.rdata  = bram_douta;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Drives three arbiter builds (RR/lat1, fixed-priority starve=2/lat1, RR/lat3) from one
// stimulus stream and checks grants and read returns against a transaction-level model.
module tb_bram_read_arbiter;
  import audio_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;

  always #5 clk = ~clk;

  logic [ND-1:0]         gnt0_o, gnt1_o, rv0_o, rv1_o, ena_o;
  logic [ND-1:0][AW-1:0] addra_o;
  logic [ND-1:0][DW-1:0] rd0_o, rd1_o;

  function automatic logic [31:0] pow4(input logic [31:0] a);
    return a * a * a * a;
  endfunction

  function automatic int lat(input int d);
    return (d == 2) ? 3 : 1;
  endfunction
  function automatic int pol(input int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int lim(input int d);
    return (d == 1) ? 2 : 8;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      localparam int LAT = (gi == 2) ? 3 : 1;
      bram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
      bram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
      logic          ena;
      logic [AW-1:0] addra;
      logic [DW-1:0] douta;
      logic [DW-1:0] bram_pipe [LAT];

      assign if0.req  = req0;
      assign if0.addr = addr0;
      assign if1.req  = req1;
      assign if1.addr = addr1;

      bram_read_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (LAT),
        .POLICY       ((gi == 1) ? 1 : 0),
        .STARVE_LIMIT ((gi == 1) ? 2 : 8)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .r0         (if0),
        .r1         (if1),
        .bram_ena   (ena),
        .bram_addra (addra),
        .bram_douta (douta)
      );

      // BRAM model: douta = addra^4, LAT clocks after the sampling edge
      always @(posedge clk) begin
        bram_pipe[0] <= pow4(addra);
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
      end
      assign douta = bram_pipe[LAT-1];

      assign gnt0_o[gi]  = if0.gnt;
      assign gnt1_o[gi]  = if1.gnt;
      assign rv0_o[gi]   = if0.rvalid;
      assign rv1_o[gi]   = if1.rvalid;
      assign rd0_o[gi]   = if0.rdata;
      assign rd1_o[gi]   = if1.rdata;
      assign ena_o[gi]   = ena;
      assign addra_o[gi] = addra;
    end
  endgenerate

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] addr;
  } pend_t;

  pend_t pend [ND][$];
  bit    last_dbg [ND];
  int    starve [ND];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic [ND-1:0] obs_g0, obs_g1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input int d, input logic r, input logic q0, input logic q1);
    if (r) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (!q0 && !q1) return -1;
    if (pol(d) == 0) return last_dbg[d] ? 0 : 1;
    return (starve[d] == lim(d)) ? 1 : 0;
  endfunction

  task automatic step(input logic r, input logic q0, input logic [31:0] a0,
                      input logic q1, input logic [31:0] a1);
    int    egs [ND];
    int    eg;
    bit    ev0, ev1;
    pend_t pe;
    logic [31:0] edata;
    rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
    if (r) begin
      for (int d = 0; d < ND; d++) begin
        last_dbg[d] = 1'b1;
        starve[d]   = 0;
        pend[d].delete();
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      eg     = exp_grant(d, r, q0, q1);
      egs[d] = eg;
      check($sformatf("c%0d_d%0d_gnt0", cyc, d), gnt0_o[d], eg == 0);
      check($sformatf("c%0d_d%0d_gnt1", cyc, d), gnt1_o[d], eg == 1);
      check($sformatf("c%0d_d%0d_ena", cyc, d), ena_o[d], eg >= 0);
      check($sformatf("c%0d_d%0d_addra", cyc, d), addra_o[d],
            (eg == 0) ? a0 : ((eg == 1) ? a1 : 32'd0));
      ev0 = 1'b0; ev1 = 1'b0; edata = '0;
      if (pend[d].size() > 0 && pend[d][0].due == cyc) begin
        pe = pend[d].pop_front();
        if (pe.id) ev1 = 1'b1; else ev0 = 1'b1;
        edata = pow4(pe.addr);
      end
      check($sformatf("c%0d_d%0d_rvalid0", cyc, d), rv0_o[d], ev0);
      check($sformatf("c%0d_d%0d_rvalid1", cyc, d), rv1_o[d], ev1);
      if (ev0) check($sformatf("c%0d_d%0d_rdata0", cyc, d), rd0_o[d], edata);
      if (ev1) check($sformatf("c%0d_d%0d_rdata1", cyc, d), rd1_o[d], edata);
    end
    obs_g0 = gnt0_o;
    obs_g1 = gnt1_o;
    $display("cyc=%0d rst=%0b req=%0b%0b gnt(d0,d1,d2)=%0b%0b,%0b%0b,%0b%0b rv=%0b%0b,%0b%0b,%0b%0b",
             cyc, r, q1, q0, gnt1_o[0], gnt0_o[0], gnt1_o[1], gnt0_o[1], gnt1_o[2], gnt0_o[2],
             rv1_o[0], rv0_o[0], rv1_o[1], rv0_o[1], rv1_o[2], rv0_o[2]);
    @(posedge clk);
    if (!r) begin
      for (int d = 0; d < ND; d++) begin
        if (egs[d] >= 0) begin
          pe.due  = cyc + lat(d);
          pe.id   = (egs[d] == 1);
          pe.addr = (egs[d] == 1) ? a1 : a0;
          pend[d].push_back(pe);
          last_dbg[d] = (egs[d] == 1);
          if (egs[d] == 1) starve[d] = 0;
          else if (q0 && q1 && starve[d] < lim(d)) starve[d]++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  logic [5:0] fp_seq;

  initial begin
    for (int d = 0; d < ND; d++) begin
      last_dbg[d] = 1'b1;
      starve[d]   = 0;
    end
    @(posedge clk);
    #1;
    // reset state, with requests present: everything must stay low
    step(1, 1, 7, 1, 8);
    step(1, 0, 0, 0, 0);
    // single r0 read of addr 3 -> 81 one cycle later (three cycles later on d2)
    step(0, 1, 3, 0, 0);
    check("single_gnt0_d0", obs_g0[0], 1'b1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // fixed-priority starvation pattern from a fresh reset
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2, 1, 5);
      fp_seq[5-i] = obs_g1[1];
    end
    check("fp_order_d1", fp_seq, 6'b001001);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // back-to-back r1 reads
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // reset right after an r0 grant drops the in-flight read
    step(0, 1, 4, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 4, 1, 6);
    step(0, 1, 7, 1, 9);
    check("post_reset_tie_d0", obs_g0[0], 1'b1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    for (int d = 0; d < ND; d++) check($sformatf("drained_d%0d", d), pend[d].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
